// File: rtl/slot_fifo_read_arbiter_if.sv
// Bundle between the read arbiter and its surroundings: the per-slot FIFOs,
// the shared FIFO memory read port and the requesting converter slots.
//
// Handshake: req[s] is a level request held by slot s until it sees done[s].
// A burst is granted only when the slot FIFO holds BURST_LEN bytes. Returned
// bytes are qualified by the one-hot data_valid; there is no back-pressure.
// mem_read/mem_slot form a strobe with fixed READ_LATENCY to mem_data.
//
// Modports:
//   master - used by the arbiter (drives strobes, returned data, flags)
//   slave  - used by the environment (drives requests, pointers, mem_data)
//
// fsm_state is a debug view of the arbiter FSM (0 = IDLE, 1 = BURST).
interface slot_fifo_read_arbiter_if #(
  parameter int NUM_SLOTS  = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int BURST_LEN  = 4
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int IDX_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [NUM_SLOTS-1:0]            req;
  logic [NUM_SLOTS*ADDR_WIDTH-1:0] fifo_addr_in;
  logic [NUM_SLOTS*ADDR_WIDTH-1:0] fifo_addr_out;
  logic                            mem_read;
  logic [SLOT_W-1:0]               mem_slot;
  logic [7:0]                      mem_data;
  logic [7:0]                      rd_data;
  logic [NUM_SLOTS-1:0]            data_valid;
  logic [IDX_W-1:0]                byte_index;
  logic [NUM_SLOTS-1:0]            done;
  logic [NUM_SLOTS-1:0]            underrun;
  logic                            underrun_clear;
  logic                            fsm_state;

  modport master (
    input  req, fifo_addr_in, fifo_addr_out, mem_data, underrun_clear,
    output mem_read, mem_slot, rd_data, data_valid, byte_index, done,
           underrun, fsm_state
  );

  modport slave (
    output req, fifo_addr_in, fifo_addr_out, mem_data, underrun_clear,
    input  mem_read, mem_slot, rd_data, data_valid, byte_index, done,
           underrun, fsm_state
  );
endinterface

// File: rtl/slot_fifo_read_arbiter.sv
// Round-robin arbiter sharing one FIFO-memory read port among NUM_SLOTS
// converter slots. A slot is granted a BURST_LEN-byte fetch only when its
// FIFO level (write pointer - read pointer, modulo 2^ADDR_WIDTH) covers the
// whole burst. Each returned byte is tagged with a one-hot owner and its
// position in the burst; done marks the last byte.
//
// Ports:
//   clk   - system clock, all logic on posedge
//   reset - synchronous, active-high; aborts any burst and flushes returns
//   bus   - slot_fifo_read_arbiter_if.master (req, FIFO pointers, memory
//           read strobe/slot/data, returned data, valid/index/done,
//           sticky underrun flags with clear, FSM debug state)
module slot_fifo_read_arbiter #(
  parameter int NUM_SLOTS    = 4,
  parameter int ADDR_WIDTH   = 11,
  parameter int BURST_LEN    = 4,
  parameter int READ_LATENCY = 2
) (
  input logic                      clk,
  input logic                      reset,
  slot_fifo_read_arbiter_if.master bus
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int IDX_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [SLOT_W-1:0]     LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] MIN_LEVEL = ADDR_WIDTH'(BURST_LEN);
  localparam logic [SLOT_W:0]       NUM_EXT   = (SLOT_W + 1)'(NUM_SLOTS);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [SLOT_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [SLOT_W-1:0]     winner;
  logic                  found;
  logic [SLOT_W:0]       scan_idx;
  logic [NUM_SLOTS-1:0]  eligible;
  logic [NUM_SLOTS-1:0]  short_req;
  logic [NUM_SLOTS-1:0]  underrun_q;
  logic [NUM_SLOTS-1:0]  underrun_set;
  logic [ADDR_WIDTH-1:0] level [NUM_SLOTS];
  logic                  mem_read_w;

  // Return pipeline: one entry per cycle of read latency.
  logic [READ_LATENCY-1:0]             pipe_valid;
  logic [READ_LATENCY-1:0][SLOT_W-1:0] pipe_slot;
  logic [READ_LATENCY-1:0][IDX_W-1:0]  pipe_idx;

  // FIFO levels; the subtraction wraps naturally at ADDR_WIDTH bits.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      level[s]     = bus.fifo_addr_in[s*ADDR_WIDTH +: ADDR_WIDTH]
                   - bus.fifo_addr_out[s*ADDR_WIDTH +: ADDR_WIDTH];
      eligible[s]  = bus.req[s] && (level[s] >= MIN_LEVEL);
      short_req[s] = bus.req[s] && (level[s] < MIN_LEVEL);
    end
  end

  // Round-robin scan starting at rr_q; the first eligible slot wins.
  // scan_idx carries one extra bit so the modulo fold works for any count.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      scan_idx = {1'b0, rr_q} + (SLOT_W + 1)'(i);
      if (scan_idx >= NUM_EXT) begin
        scan_idx = scan_idx - NUM_EXT;
      end
      if (!found && eligible[scan_idx[SLOT_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[SLOT_W-1:0];
      end
    end
  end

  // FSM next state and outputs. Levels and underruns are only looked at in
  // IDLE; a grant is never cut short by req dropping during BURST.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    underrun_set = '0;
    mem_read_w   = 1'b0;
    case (state_q)
      IDLE: begin
        underrun_set = short_req;
        if (found) begin
          state_d = BURST;
          slot_d  = winner;
          cnt_d   = '0;
        end
      end
      BURST: begin
        mem_read_w = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          rr_d    = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      // A new underrun in the same cycle as a clear must survive.
      underrun_q <= (underrun_q & ~{NUM_SLOTS{bus.underrun_clear}}) | underrun_set;
    end
  end

  // Tag each issued read with its owner and byte position, delayed to line
  // up with mem_data. Reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_slot  <= '0;
      pipe_idx   <= '0;
    end else begin
      pipe_valid[0] <= mem_read_w;
      pipe_slot[0]  <= slot_q;
      pipe_idx[0]   <= cnt_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_slot[i]  <= pipe_slot[i-1];
        pipe_idx[i]   <= pipe_idx[i-1];
      end
    end
  end

  always_comb begin
    bus.data_valid = '0;
    bus.done       = '0;
    bus.byte_index = '0;
    if (pipe_valid[READ_LATENCY-1]) begin
      bus.data_valid[pipe_slot[READ_LATENCY-1]] = 1'b1;
      bus.byte_index = pipe_idx[READ_LATENCY-1];
      if (pipe_idx[READ_LATENCY-1] == LAST_IDX) begin
        bus.done[pipe_slot[READ_LATENCY-1]] = 1'b1;
      end
    end
  end

  assign bus.mem_read  = mem_read_w;
  assign bus.mem_slot  = slot_q;
  assign bus.rd_data   = bus.mem_data;
  assign bus.underrun  = underrun_q;
  assign bus.fsm_state = state_q;
endmodule
